// File: rtl/ball_ctl.sv
// Ball position/velocity controller for a two-player volley game, stepped once per frame tick.
// Define BALL_CTL_GRAVITY_EN to add gravity to the vertical velocity during flight.
module ball_ctl (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vblnk,
    input  logic              start,
    input  logic              serve_side,
    input  logic              pl1_col,
    input  logic              pl2_col,
    input  logic              net_col,
    output logic [11:0]       xpos,
    output logic [11:0]       ypos,
    output logic signed [7:0] vx,
    output logic signed [7:0] vy,
    output logic [1:0]        state,
    output logic              pl1_point,
    output logic              pl2_point
);
    localparam int unsigned POS_W  = 12;
    localparam int unsigned V_W    = 8;
    localparam int unsigned VS_W   = V_W + 1;
    localparam int unsigned CAND_W = 13;

    localparam int unsigned SCREEN_W    = 800;
    localparam int unsigned GROUND_Y    = 550;
    localparam int unsigned NET_X       = 400;
    localparam int unsigned BALL_SIZE   = 64;
    localparam int unsigned PL1_SERVE_X = 168;
    localparam int unsigned PL2_SERVE_X = 568;
    localparam int unsigned SERVE_Y     = 100;
    localparam int unsigned BOUNCE_V    = 12;
    localparam int unsigned VX_HIT      = 4;
    localparam int unsigned VMAX        = 15;
    localparam int unsigned SCORE_HOLD  = 60;
    localparam int unsigned CNT_W       = $clog2(SCORE_HOLD);

    localparam int unsigned X_MAX = SCREEN_W - BALL_SIZE;
    localparam int unsigned Y_GND = GROUND_Y - BALL_SIZE;

    localparam logic [POS_W-1:0] PL1_X   = POS_W'(PL1_SERVE_X);
    localparam logic [POS_W-1:0] PL2_X   = POS_W'(PL2_SERVE_X);
    localparam logic [POS_W-1:0] SRV_Y   = POS_W'(SERVE_Y);
    localparam logic [POS_W-1:0] X_MAX_P = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_GND_P = POS_W'(Y_GND);

    localparam logic signed [CAND_W-1:0] X_MAX_S = $signed(CAND_W'(X_MAX));
    localparam logic signed [CAND_W-1:0] Y_GND_S = $signed(CAND_W'(Y_GND));
    localparam logic signed [CAND_W-1:0] HALF_S  = $signed(CAND_W'(BALL_SIZE / 2));
    localparam logic signed [CAND_W-1:0] NET_S   = $signed(CAND_W'(NET_X));

    localparam logic signed [V_W-1:0]  VX_HIT_S = $signed(V_W'(VX_HIT));
    localparam logic signed [V_W-1:0]  BOUNCE_S = $signed(V_W'(BOUNCE_V));
    localparam logic signed [VS_W-1:0] VMAX_S   = $signed(VS_W'(VMAX));
`ifdef BALL_CTL_GRAVITY_EN
    localparam int unsigned            GRAVITY  = 1;
    localparam logic signed [VS_W-1:0] GRAV_S   = $signed(VS_W'(GRAVITY));
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE  = 2'd1,
        FLIGHT = 2'd2,
        SCORE  = 2'd3
    } state_t;

    state_t                   st_q, st_d;
    logic                     vblnk_q;
    logic                     tick_c;
    logic                     c1_q, c2_q, cn_q;
    logic                     side_q, side_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [POS_W-1:0]         xpos_d, ypos_d;
    logic signed [V_W-1:0]    vx_d, vy_d;
    logic                     pl1_d, pl2_d;

    logic signed [V_W-1:0]    vx_sel, vy_sel, vx_wall, vy_ceil;
    logic signed [CAND_W-1:0] cx, cy, mid_x;
    logic [POS_W-1:0]         x_clamp, y_clamp;
    logic                     hit_wall, hit_ceil, landed;
    logic signed [VS_W-1:0]   vx_ext, vy_ext;
    logic signed [V_W-1:0]    vx_sat, vy_sat;

    function automatic logic signed [V_W-1:0] sat_v(input logic signed [VS_W-1:0] v);
        if (v > VMAX_S)
            return V_W'(VMAX_S);
        else if (v < -VMAX_S)
            return V_W'(-VMAX_S);
        else
            return V_W'(v);
    endfunction

    assign tick_c = vblnk & ~vblnk_q;
    assign state  = st_q;

    // Per-frame physics step: velocity select, candidate move, walls/ceiling, saturation.
    always_comb begin
        vx_sel = vx;
        vy_sel = vy;
        if (c1_q) begin
            vx_sel = VX_HIT_S;
            vy_sel = -BOUNCE_S;
        end else if (c2_q) begin
            vx_sel = -VX_HIT_S;
            vy_sel = -BOUNCE_S;
        end else if (cn_q) begin
            vx_sel = -vx;
        end

        cx    = $signed({1'b0, xpos}) + $signed({{(CAND_W-V_W){vx_sel[V_W-1]}}, vx_sel});
        cy    = $signed({1'b0, ypos}) + $signed({{(CAND_W-V_W){vy_sel[V_W-1]}}, vy_sel});
        mid_x = cx + HALF_S;

        hit_wall = 1'b0;
        x_clamp  = POS_W'(cx);
        if (cx[CAND_W-1]) begin
            hit_wall = 1'b1;
            x_clamp  = '0;
        end else if (cx > X_MAX_S) begin
            hit_wall = 1'b1;
            x_clamp  = X_MAX_P;
        end

        hit_ceil = cy[CAND_W-1];
        y_clamp  = hit_ceil ? '0 : POS_W'(cy);

        landed  = !cy[CAND_W-1] && (cy >= Y_GND_S) && !c1_q && !c2_q;
        vx_wall = hit_wall ? -vx_sel : vx_sel;
        vy_ceil = hit_ceil ? -vy_sel : vy_sel;
        vx_ext  = $signed({vx_wall[V_W-1], vx_wall});
`ifdef BALL_CTL_GRAVITY_EN
        vy_ext  = $signed({vy_ceil[V_W-1], vy_ceil}) + GRAV_S;
`else
        vy_ext  = $signed({vy_ceil[V_W-1], vy_ceil});
`endif
        vx_sat  = sat_v(vx_ext);
        vy_sat  = sat_v(vy_ext);
    end

    // Next-state and registered-output logic.
    always_comb begin
        st_d   = st_q;
        xpos_d = xpos;
        ypos_d = ypos;
        vx_d   = vx;
        vy_d   = vy;
        side_d = side_q;
        cnt_d  = cnt_q;
        pl1_d  = 1'b0;
        pl2_d  = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (start) begin
                    st_d   = SERVE;
                    side_d = serve_side;
                end
            end
            SERVE: begin
                if (tick_c) begin
                    xpos_d = side_q ? PL2_X : PL1_X;
                    ypos_d = SRV_Y;
                    vx_d   = '0;
                    vy_d   = '0;
                    st_d   = FLIGHT;
                end
            end
            FLIGHT: begin
                if (tick_c) begin
                    xpos_d = x_clamp;
                    if (landed) begin
                        st_d   = SCORE;
                        ypos_d = Y_GND_P;
                        vx_d   = '0;
                        vy_d   = '0;
                        cnt_d  = '0;
                        if (mid_x < NET_S) begin
                            pl2_d  = 1'b1;
                            side_d = 1'b1;
                        end else begin
                            pl1_d  = 1'b1;
                            side_d = 1'b0;
                        end
                    end else begin
                        ypos_d = y_clamp;
                        vx_d   = vx_sat;
                        vy_d   = vy_sat;
                    end
                end
            end
            SCORE: begin
                if (tick_c) begin
                    if (cnt_q == CNT_W'(SCORE_HOLD - 1)) begin
                        st_d  = SERVE;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // State, datapath and sticky collision registers; collisions on the tick cycle start the next frame.
    always_ff @(posedge pclk) begin
        if (rst) begin
            st_q      <= IDLE;
            xpos      <= PL1_X;
            ypos      <= SRV_Y;
            vx        <= '0;
            vy        <= '0;
            side_q    <= 1'b0;
            cnt_q     <= '0;
            pl1_point <= 1'b0;
            pl2_point <= 1'b0;
            vblnk_q   <= 1'b0;
            c1_q      <= 1'b0;
            c2_q      <= 1'b0;
            cn_q      <= 1'b0;
        end else begin
            st_q      <= st_d;
            xpos      <= xpos_d;
            ypos      <= ypos_d;
            vx        <= vx_d;
            vy        <= vy_d;
            side_q    <= side_d;
            cnt_q     <= cnt_d;
            pl1_point <= pl1_d;
            pl2_point <= pl2_d;
            vblnk_q   <= vblnk;
            if (tick_c) begin
                c1_q <= pl1_col;
                c2_q <= pl2_col;
                cn_q <= net_col;
            end else begin
                c1_q <= c1_q | pl1_col;
                c2_q <= c2_q | pl2_col;
                cn_q <= cn_q | net_col;
            end
        end
    end

endmodule

// File: tb/tb_ball_ctl.sv
// Directed bench for ball_ctl: serve, per-frame motion, collision priority, scoring and re-serve.
`timescale 1ns/1ps
module tb_ball_ctl;
`ifdef BALL_CTL_GRAVITY_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif

    logic              pclk = 1'b0;
    logic              rst, vblnk, start, serve_side;
    logic              pl1_col, pl2_col, net_col;
    logic [11:0]       xpos, ypos;
    logic signed [7:0] vx, vy;
    logic [1:0]        state;
    logic              pl1_point, pl2_point;

    int n_asserts = 0;
    int n_fail    = 0;
    int p1_cnt    = 0;
    int p2_cnt    = 0;
    int p1s, p2s, n, srv_x;

    ball_ctl dut (
        .pclk(pclk), .rst(rst), .vblnk(vblnk), .start(start), .serve_side(serve_side),
        .pl1_col(pl1_col), .pl2_col(pl2_col), .net_col(net_col),
        .xpos(xpos), .ypos(ypos), .vx(vx), .vy(vy), .state(state),
        .pl1_point(pl1_point), .pl2_point(pl2_point)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (pl1_point) p1_cnt++;
        if (pl2_point) p2_cnt++;
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge pclk) vblnk = 1'b1;
        @(negedge pclk) vblnk = 1'b0;
        @(negedge pclk);
    endtask

    task automatic col(input logic c1, input logic c2, input logic cn);
        @(negedge pclk) begin pl1_col = c1; pl2_col = c2; net_col = cn; end
        @(negedge pclk) begin pl1_col = 1'b0; pl2_col = 1'b0; net_col = 1'b0; end
    endtask

    task automatic do_start(input logic side);
        @(negedge pclk) begin start = 1'b1; serve_side = side; end
        @(negedge pclk) start = 1'b0;
    endtask

    task automatic run_to_score(input int max, output int cnt);
        cnt = 0;
        while (state != 2'd3 && cnt < max) begin
            tick();
            cnt++;
        end
        check("rally_ends_in_score", state, 3);
    endtask

    task automatic hold_and_reserve(input int exp_x);
        repeat (59) tick();
        check("score_hold_59", state, 3);
        check("score_hold_y", ypos, 486);
        tick();
        check("score_hold_60", state, 1);
        tick();
        check("reserve_state", state, 2);
        check("reserve_x", xpos, exp_x);
        check("reserve_y", ypos, 100);
    endtask

    initial begin
        rst = 1'b1; vblnk = 1'b0; start = 1'b1; serve_side = 1'b1;
        pl1_col = 1'b0; pl2_col = 1'b0; net_col = 1'b0;
        repeat (2) @(negedge pclk);
        @(negedge pclk) vblnk = 1'b1;
        @(negedge pclk) vblnk = 1'b0;
        check("rst_state", state, 0);
        check("rst_x", xpos, 168);
        check("rst_y", ypos, 100);
        check("rst_vx", vx, 0);
        check("rst_vy", vy, 0);
        check("rst_pl1", pl1_point, 0);
        check("rst_pl2", pl2_point, 0);
        @(negedge pclk) begin rst = 1'b0; start = 1'b0; end
        @(negedge pclk);
        check("idle_after_rst", state, 0);

        // Serve from pl1 and free flight
        do_start(1'b0);
        check("start_to_serve", state, 1);
        tick();
        check("serve_state", state, 2);
        check("serve_x", xpos, 168);
        check("serve_y", ypos, 100);
        check("serve_vx", vx, 0);
        check("serve_vy", vy, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("free_y", ypos, 100 + G * k * (k - 1) / 2);
            check("free_vy", vy, G * k);
        end
        check("free_x", xpos, 168);

        // pl2 collision only on the tick cycle counts for the next frame
        @(negedge pclk) begin vblnk = 1'b1; pl2_col = 1'b1; end
        @(negedge pclk) begin vblnk = 1'b0; pl2_col = 1'b0; end
        @(negedge pclk);
        check("tickcol_vx_deferred", vx, 0);
        check("tickcol_y", ypos, 100 + 10 * G);
        tick();
        check("c2_vx", vx, -4);
        check("c2_vy", vy, -12 + G);
        check("c2_x", xpos, 164);
        check("c2_y", ypos, 88 + 10 * G);

        // pl1 beats pl2
        col(1'b1, 1'b1, 1'b0);
        tick();
        check("c1c2_vx", vx, 4);
        check("c1c2_x", xpos, 168);
        check("c1c2_y", ypos, 76 + 10 * G);
        check("c1c2_vy", vy, -12 + G);

        // net reverses vx only; start ignored mid-rally
        col(1'b0, 1'b0, 1'b1);
        do_start(1'b1);
        tick();
        check("net_vx", vx, -4);
        check("net_x", xpos, 164);
        check("net_y", ypos, 64 + 11 * G);
        check("net_vy", vy, -12 + 2 * G);
        check("start_ignored", state, 2);

        // Reset coinciding with a tick aborts the rally
        p1s = p1_cnt; p2s = p2_cnt;
        @(negedge pclk) begin vblnk = 1'b1; rst = 1'b1; end
        @(negedge pclk) vblnk = 1'b0;
        check("abort_state", state, 0);
        check("abort_x", xpos, 168);
        check("abort_y", ypos, 100);
        check("abort_vx", vx, 0);
        check("abort_vy", vy, 0);
        @(negedge pclk) rst = 1'b0;
        repeat (2) @(negedge pclk);
        check("abort_no_point", (p1_cnt - p1s) + (p2_cnt - p2s), 0);

        // Rally A: pl1 hit, ceiling bounce, lands exactly at the net split
        do_start(1'b0);
        tick();
        check("rallyA_serve_x", xpos, 168);
        col(1'b1, 1'b0, 1'b0);
        tick();
        check("rallyA_hit_x", xpos, 172);
        check("rallyA_hit_y", ypos, 88);
        check("rallyA_hit_vx", vx, 4);
        check("rallyA_hit_vy", vy, -12 + G);
        p1s = p1_cnt; p2s = p2_cnt;
        run_to_score(300, n);
        @(negedge pclk);
        check("rallyA_land_y", ypos, 486);
        check("rallyA_land_vx", vx, 0);
        check("rallyA_land_vy", vy, 0);
        check("rallyA_one_point", (p1_cnt - p1s) + (p2_cnt - p2s), 1);
`ifdef BALL_CTL_GRAVITY_EN
        srv_x = (p2_cnt != p2s) ? 568 : 168;
`else
        check("rallyA_ticks", n, 49);
        check("rallyA_land_x", xpos, 368);
        check("rallyA_pl1_point", p1_cnt - p1s, 1);
        srv_x = 168;
`endif
        hold_and_reserve(srv_x);

        // Rally B: pl2 hit, left wall bounce, lands in pl1 half
        col(1'b0, 1'b1, 1'b0);
        tick();
        check("rallyB_hit_x", xpos, srv_x - 4);
        check("rallyB_hit_y", ypos, 88);
        check("rallyB_hit_vx", vx, -4);
        p1s = p1_cnt; p2s = p2_cnt;
        run_to_score(300, n);
        @(negedge pclk);
        check("rallyB_land_y", ypos, 486);
        check("rallyB_one_point", (p1_cnt - p1s) + (p2_cnt - p2s), 1);
`ifdef BALL_CTL_GRAVITY_EN
        srv_x = (p2_cnt != p2s) ? 568 : 168;
`else
        check("rallyB_ticks", n, 49);
        check("rallyB_land_x", xpos, 28);
        check("rallyB_pl2_point", p2_cnt - p2s, 1);
        srv_x = 568;
`endif
        hold_and_reserve(srv_x);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/ball_ctl.md
BALL_CTL -- requirements
Module: ball_ctl

Interface
REQ-001 SCREEN_W, 800, active width in pixels.
REQ-002 GROUND_Y, 550, ground line y; ball bottom edge reaching it ends the rally.
REQ-003 NET_X, 400, x of net centre; splits the court into pl1 (left) and pl2 (right) halves.
REQ-004 BALL_SIZE, 64, ball sprite width and height.
REQ-005 PL1_SERVE_X / PL2_SERVE_X / SERVE_Y, 168 / 568 / 100, serve positions (top-left).
REQ-006 GRAVITY, 1; BOUNCE_V, 12; VX_HIT, 4; VMAX, 15: velocity constants in px/frame.
REQ-007 SCORE_HOLD, 60, frames held in SCORE before re-serve.
REQ-008 pclk  in  1  pixel clock; all logic on its rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 vblnk  in  1  vertical blank from the timing chain; its rising edge is the frame tick.
REQ-011 start  in  1  one-cycle request to begin a rally; honoured in IDLE only.
REQ-012 serve_side  in  1  side that serves the first rally: 0 = pl1, 1 = pl2.
REQ-013 pl1_col / pl2_col / net_col  in  1 each  per-pixel collision flags from the ball renderer.
REQ-014 xpos / ypos  out  12 each  ball top-left position, registered, fed to the ball renderer.
REQ-015 vx / vy  out  8 each  signed two's-complement velocity, registered.
REQ-016 state  out  2  IDLE=0, SERVE=1, FLIGHT=2, SCORE=3.
REQ-017 pl1_point / pl2_point  out  1 each  one-cycle point pulses.

Function
REQ-018 tick SHALL be vblnk high while the registered previous vblnk is low; all outputs except pulses SHALL update on the cycle after the tick, and only then.
REQ-019 Sticky flags c1/c2/cn SHALL set on any cycle with the matching collision input high; on the tick cycle they SHALL be sampled and then cleared, a collision on the tick cycle itself counting toward the next frame.
REQ-020 IDLE: hold position; start -> SERVE with the latched serve side = serve_side; start in other states SHALL be ignored.
REQ-021 SERVE: on tick, load xpos = serve side ? PL2_SERVE_X : PL1_SERVE_X, ypos = SERVE_Y, vx = vy = 0 -> FLIGHT.
REQ-022 FLIGHT step 1, velocity select on tick: c1 -> vx=+VX_HIT, vy=-BOUNCE_V; else c2 -> vx=-VX_HIT, vy=-BOUNCE_V; else cn -> vx=-vx; else unchanged; c1 beats c2, and both beat cn.
REQ-023 Step 2: candidate position = position + selected velocity, computed in signed 13-bit arithmetic.
REQ-024 Step 3: if candidate y >= GROUND_Y-BALL_SIZE and neither c1 nor c2 was set, go to SCORE.
REQ-025 In that case, pl2_point SHALL pulse if candidate x + BALL_SIZE/2 < NET_X, else pl1_point; the scorer becomes the serve side.
REQ-026 In that case, ypos = GROUND_Y-BALL_SIZE and vx = vy = 0.
REQ-027 Step 4, walls: candidate x < 0 -> xpos = 0, vx negated; candidate x > SCREEN_W-BALL_SIZE -> xpos = SCREEN_W-BALL_SIZE, vx negated.
REQ-028 Step 4, ceiling: candidate y < 0 -> ypos = 0, vy negated.
REQ-029 Step 5: vy SHALL take the gravity update per REQ-037, then saturate to [-VMAX, +VMAX]; vx SHALL saturate likewise.
REQ-030 SCORE: a frame counter SHALL count ticks; at SCORE_HOLD ticks -> SERVE, counter cleared.
REQ-031 Point pulses SHALL be exactly one pclk wide and never both high.

Reset
REQ-032 On rst, in the same cycle: state = IDLE, xpos = PL1_SERVE_X, ypos = SERVE_Y, vx = vy = 0.
REQ-033 On rst: pulses, sticky flags, frame counter and serve side = 0, vblnk history = 0.
REQ-034 rst mid-rally SHALL abort with no point pulse; rst SHALL override start and tick.

Configuration
REQ-035 Macro BALL_CTL_GRAVITY_EN.
REQ-036 Without the macro: vy changes only by collision, wall or ceiling rules (pong-style).
REQ-037 With the macro: step 5 SHALL add GRAVITY to vy in FLIGHT before saturation; without it, step 5 adds nothing.

Verification
REQ-038 rst, start=1 with serve_side=0, one tick -> state=2, xpos=168, ypos=100, vx=vy=0.
REQ-039 GRAVITY_EN, no collisions, 4 ticks after serve -> ypos 100,101,103,106; vy 1,2,3,4.
REQ-040 pl1_col pulse mid-frame at xpos=300, ypos=200 -> after tick xpos=304, ypos=188, vx=+4, vy=-11 (GRAVITY_EN).
REQ-041 Ball falls to y>=486 with x=100 -> one-cycle pl2_point, state=3; after 60 ticks SERVE, then xpos=568.
REQ-042 pl1_col and pl2_col in one frame -> vx=+4; pl2_col only on the tick cycle -> applied at the following tick.
REQ-043 Macro off, serve then 10 ticks with no collision -> ypos stays 100, vy stays 0; rst at tick 5 -> state=0, no point pulse.
